// File: rtl/lsu_pkg.sv
// Shared types and helpers for the Q4 load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;

  // funct3[1:0] gives the access size; the undefined codes fall into the word case.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lsu_misaligned = 1'b0;
      2'b01:   lsu_misaligned = off[0];
      default: lsu_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] lsu_store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   lsu_store_be = 4'b0001 << off;
      2'b01:   lsu_store_be = 4'b0011 << off;
      default: lsu_store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lsu_store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   lsu_store_wdata = {4{d[7:0]}};
      2'b01:   lsu_store_wdata = {2{d[15:0]}};
      default: lsu_store_wdata = d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select plus sign/zero extension; purely combinational.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   data = {24'd0, lane[7:0]};
      F3_HU:   data = {16'd0, lane[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/q4_lsu.sv
// Q4 memory-access stage: one req/gnt/rvalid transaction per load/store, stalls upstream meanwhile.
module q4_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_mem_rd,
  input  logic                  i_mem_wr,
  input  logic [31:0]           i_alu_out,
  input  logic [31:0]           i_reg_rd_data2,
  input  logic [31:0]           i_instr,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [31:0]           o_rd_data,
  output logic                  o_misaligned,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [3:0]            o_dmem_be,
  output logic [31:0]           o_dmem_wdata,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [31:0]           i_dmem_rdata
);

  lsu_state_t            state_q, state_d;
  logic [2:0]            f3, f3_q;
  logic [1:0]            off, off_q;
  logic                  access, mis, start;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q, rd_data_q, ld_data;
  logic                  we_q;
  logic                  unused_instr;

  assign f3     = i_instr[14:12];
  assign off    = i_alu_out[1:0];
  assign access = i_valid & (i_mem_rd | i_mem_wr);
  assign mis    = lsu_misaligned(f3, off);
  assign start  = (state_q == IDLE) & access & ~mis;

  assign unused_instr = ^{i_instr[31:15], i_instr[11:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ:     if (i_dmem_gnt) state_d = we_q ? DONE : RESP;
      RESP:    if (i_dmem_rvalid) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= {i_alu_out[ADDR_WIDTH-1:2], 2'b00};
        // rd wins when both control bits are set
        be_q    <= i_mem_rd ? 4'b1111 : lsu_store_be(f3, off);
        wdata_q <= lsu_store_wdata(f3, i_reg_rd_data2);
        we_q    <= ~i_mem_rd;
        f3_q    <= f3;
        off_q   <= off;
      end
      if (state_q == RESP && i_dmem_rvalid) rd_data_q <= ld_data;
    end
  end

  lsu_load_align u_align (
    .rdata  (i_dmem_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );

  assign o_stall      = start | (state_q == REQ) | (state_q == RESP);
  assign o_misaligned = (state_q == IDLE) & access & mis;
  assign o_done       = (state_q == DONE);
  assign o_rd_data    = rd_data_q;
  assign o_dmem_req   = (state_q == REQ);
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;

endmodule

// File: tb/tb_q4_lsu.sv
// Directed and randomized checks of q4_lsu against an arithmetic reference model.
module tb_q4_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_mem_rd, i_mem_wr;
  logic [31:0] i_alu_out, i_reg_rd_data2, i_instr;
  logic        o_stall, o_done, o_misaligned;
  logic [31:0] o_rd_data;
  logic        o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_gnt, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] model_rd = 32'd0;

  always #5 i_clk = ~i_clk;

  q4_lsu #(.ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_mem_rd(i_mem_rd),
    .i_mem_wr(i_mem_wr), .i_alu_out(i_alu_out), .i_reg_rd_data2(i_reg_rd_data2),
    .i_instr(i_instr), .o_stall(o_stall), .o_done(o_done), .o_rd_data(o_rd_data),
    .o_misaligned(o_misaligned), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
    .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int acc_size(input bit ld, input logic [2:0] f3);
    if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  // Reference load result: shift the addressed byte/half down, then extend by arithmetic.
  function automatic logic [31:0] exp_load(input logic [31:0] rdata, input int off, input logic [2:0] f3);
    longint lane, v;
    lane = longint'(rdata) >> (8 * off);
    case (f3)
      3'd0: begin v = lane % 256;   if (v >= 128)   v -= 256;   end
      3'd1: begin v = lane % 65536; if (v >= 32768) v -= 65536; end
      3'd4: v = lane % 256;
      3'd5: v = lane % 65536;
      default: v = longint'(rdata);
    endcase
    return v[31:0];
  endfunction

  task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] f3, input int gdly, input int rdly, input logic [31:0] rdata);
    bit ld;
    bit mis;
    int sz, off;
    logic [3:0]  ebe;
    logic [31:0] ewd, eaddr;
    ld  = rd;
    sz  = acc_size(ld, f3);
    off = int'(addr % 4);
    mis = (addr % sz) != 0;
    eaddr = addr - (addr % 4);
    ebe = ld ? 4'hF : (sz == 4 ? 4'hF : 4'((sz == 1 ? 1 : 3) << off));
    ewd = sz == 1 ? (data % 256) * 32'h01010101 : sz == 2 ? (data % 65536) * 32'h00010001 : data;
    i_valid = 1'b1; i_mem_rd = rd; i_mem_wr = wr; i_alu_out = addr; i_reg_rd_data2 = data;
    i_instr = {17'd0, f3, 5'd0, ld ? 7'b0000011 : 7'b0100011};
    @(negedge i_clk);
    chk("misaligned", 32'(o_misaligned), 32'(mis));
    chk("idle_stall", 32'(o_stall), 32'(!mis));
    chk("idle_req", 32'(o_dmem_req), 32'd0);
    tick();
    if (mis) begin
      i_valid = 1'b0;
      @(negedge i_clk);
      chk("mis_no_req", 32'(o_dmem_req), 32'd0);
      tick();
      return;
    end
    for (int k = 0; k <= gdly; k++) begin
      i_dmem_gnt = (k == gdly);
      i_dmem_rvalid = (k != gdly);
      i_dmem_rdata = $urandom;
      @(negedge i_clk);
      chk("req", 32'(o_dmem_req), 32'd1);
      chk("req_addr", o_dmem_addr, eaddr);
      chk("req_be", 32'(o_dmem_be), 32'(ebe));
      chk("req_we", 32'(o_dmem_we), 32'(!ld));
      if (!ld) chk("req_wdata", o_dmem_wdata, ewd);
      chk("req_stall", 32'(o_stall), 32'd1);
      tick();
    end
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    if (ld) begin
      for (int k = 1; k <= rdly; k++) begin
        i_dmem_gnt = 1'b1;
        i_dmem_rvalid = (k == rdly);
        i_dmem_rdata = (k == rdly) ? rdata : $urandom;
        @(negedge i_clk);
        chk("resp_req", 32'(o_dmem_req), 32'd0);
        chk("resp_stall", 32'(o_stall), 32'd1);
        chk("resp_done", 32'(o_done), 32'd0);
        tick();
      end
      model_rd = exp_load(rdata, off, f3);
    end
    // junk bus activity in DONE must be ignored
    i_dmem_gnt = 1'b1; i_dmem_rvalid = 1'b1; i_dmem_rdata = ~rdata;
    @(negedge i_clk);
    chk("done", 32'(o_done), 32'd1);
    chk("done_stall", 32'(o_stall), 32'd0);
    chk("done_req", 32'(o_dmem_req), 32'd0);
    chk("rd_data", o_rd_data, model_rd);
    tick();
    i_valid = 1'b0; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
    @(negedge i_clk);
    chk("post_done", 32'(o_done), 32'd0);
    chk("post_req", 32'(o_dmem_req), 32'd0);
    chk("rd_hold", o_rd_data, model_rd);
    tick();
  endtask

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_mem_rd = 1'b0; i_mem_wr = 1'b0;
    i_alu_out = '0; i_reg_rd_data2 = '0; i_instr = '0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
    #3;
    chk("rst_req", 32'(o_dmem_req), 32'd0);
    chk("rst_we", 32'(o_dmem_we), 32'd0);
    chk("rst_addr", o_dmem_addr, 32'd0);
    chk("rst_be", 32'(o_dmem_be), 32'd0);
    chk("rst_wdata", o_dmem_wdata, 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rd", o_rd_data, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_mis", 32'(o_misaligned), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();

    do_access(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 3'd2, 0, 1, 32'h0);
    do_access(1'b0, 1'b1, 32'h203, 32'h000000A5, 3'd0, 0, 1, 32'h0);
    do_access(1'b1, 1'b0, 32'h101, 32'h0, 3'd0, 2, 3, 32'h0000F100);
    chk("lb_val", o_rd_data, 32'hFFFFFFF1);
    do_access(1'b1, 1'b0, 32'h101, 32'h0, 3'd4, 0, 1, 32'h0000F100);
    chk("lbu_val", o_rd_data, 32'h000000F1);
    do_access(1'b1, 1'b0, 32'h102, 32'h0, 3'd1, 1, 1, 32'h80010000);
    chk("lh_val", o_rd_data, 32'hFFFF8001);
    do_access(1'b1, 1'b0, 32'h106, 32'h0, 3'd2, 0, 1, 32'h0);

    // ADDI: no memory access, no stall
    i_valid = 1'b1; i_mem_rd = 1'b0; i_mem_wr = 1'b0; i_instr = 32'h00500093; i_alu_out = 32'h5;
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk);
      chk("addi_stall", 32'(o_stall), 32'd0);
      chk("addi_req", 32'(o_dmem_req), 32'd0);
      chk("addi_done", 32'(o_done), 32'd0);
      tick();
    end
    i_valid = 1'b0;

    // reset while waiting in RESP, then a late rvalid
    i_valid = 1'b1; i_mem_rd = 1'b1; i_alu_out = 32'h104; i_instr = {17'd0, 3'd2, 12'h003};
    tick();
    i_dmem_gnt = 1'b1;
    tick();
    i_dmem_gnt = 1'b0;
    i_valid = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("mrst_req", 32'(o_dmem_req), 32'd0);
    chk("mrst_rd", o_rd_data, 32'd0);
    chk("mrst_stall", 32'(o_stall), 32'd0);
    tick();
    i_rst_n = 1'b1;
    model_rd = 32'd0;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk("late_done", 32'(o_done), 32'd0);
      chk("late_req", 32'(o_dmem_req), 32'd0);
      chk("late_rd", o_rd_data, 32'd0);
      tick();
    end
    i_dmem_rvalid = 1'b0;

    for (int n = 0; n < 60; n++) begin
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] a;
      int sz;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd) f3 = 3'($urandom_range(0, 7));
      else begin
        f3 = 3'($urandom_range(0, 5));
        if (f3 > 3'd3) f3 = f3 + 3'd2;
      end
      a = $urandom;
      sz = acc_size(rd, f3);
      if ($urandom_range(0, 3) != 0) a = a - (a % sz);
      do_access(rd, wr, a, $urandom, f3, $urandom_range(0, 2), $urandom_range(1, 3), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
